// File: rtl/hat_pkg.sv
// Shared defaults, the issue-tag record and a pointer helper for the hat scheduler.
package hat_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 32;
    localparam int OW_DEF   = 16;
    localparam int LAT_DEF  = 3;

    // Index width covers the largest supported requester count (8).
    localparam int IDX_W = 3;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    // Round-robin successor of a requester index, wrapping at n.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input int n);
        if (int'(idx) == n - 1) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: the first requester at or after ptr wins, one-hot grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [N-1:0] req_rot;
    logic [N-1:0] gnt_rot;

    // Rotate so bit 0 is the requester at ptr, isolate the lowest set bit, rotate back.
    assign req_rot = N'({req, req} >> ptr);
    assign gnt_rot = req_rot & (~req_rot + N'(1));
    assign gnt     = N'(({gnt_rot, gnt_rot} << ptr) >> N);

endmodule

// File: rtl/hat_sched.sv
// Round-robin issue of requester words into one shared fixed-latency hat datapath,
// with a tag pipeline routing each result back to a one-deep per-requester buffer.
module hat_sched
    import hat_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int OW   = OW_DEF,
    parameter int LAT  = LAT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic [DW-1:0]      dp_in,
    input  logic [OW-1:0]      dp_out,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [NREQ*OW-1:0] rsp_data,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic               busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    tag_t             pipe [LAT];
    tag_t             exit_tag;
    logic [NREQ-1:0]  inflight;
    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  gnt;
    logic [PW-1:0]    ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             pipe_busy;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        inflight  = '0;
        pipe_busy = 1'b0;
        for (int s = 0; s < LAT; s++) begin
            pipe_busy = pipe_busy | pipe[s].valid;
            for (int i = 0; i < NREQ; i++) begin
                if (pipe[s].valid && pipe[s].idx == IDX_W'(i)) begin
                    inflight[i] = 1'b1;
                end
            end
        end
    end

    // A full buffer still qualifies when it is being drained this very cycle.
    assign eligible = req_valid & {NREQ{en}} & ~inflight & (~rsp_valid | rsp_ready);

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_arb (
        .req (eligible),
        .ptr (ptr),
        .gnt (gnt)
    );

    // Reset gates the combinational grant path so nothing escapes while held.
    assign req_ready = reset ? gnt : '0;
    assign gnt_any   = |req_ready;

    always_comb begin
        gnt_idx = '0;
        dp_in   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                gnt_idx = IDX_W'(i);
                dp_in   = req_data[i*DW +: DW];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < LAT; s++) begin
                pipe[s] <= '0;
            end
            ptr <= '0;
        end else begin
            pipe[0] <= tag_t'{valid: gnt_any, idx: gnt_idx};
            for (int s = 1; s < LAT; s++) begin
                pipe[s] <= pipe[s-1];
            end
            if (gnt_any) begin
                ptr <= PW'(next_idx(gnt_idx, NREQ));
            end
        end
    end

    assign exit_tag = pipe[LAT-1];

    // NOTE: the response buffers are reset as well, because rsp_data must read zero during reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                // A capture outranks a drain on the same edge so the new result survives.
                if (exit_tag.valid && exit_tag.idx == IDX_W'(i)) begin
                    rsp_valid[i]          <= 1'b1;
                    rsp_data[i*OW +: OW]  <= dp_out;
                end else if (rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign busy = pipe_busy | (|rsp_valid);

endmodule

// File: tb/tb_hat_sched.sv
// Self-checking bench for hat_sched: directed scenarios plus random traffic against a
// transaction-level model of grants, pending results and response buffers.
module tb_hat_sched;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int OW   = 16;
    localparam int LAT  = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               en;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [DW-1:0]      dp_in;
    logic [OW-1:0]      dp_out;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ*OW-1:0] rsp_data;
    logic [NREQ-1:0]    rsp_ready;
    logic               busy;

    always #5 clk = ~clk;

    hat_sched #(
        .NREQ (NREQ),
        .DW   (DW),
        .OW   (OW),
        .LAT  (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .dp_in     (dp_in),
        .dp_out    (dp_out),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    // Hat shape: sum of two halved uniform halves gives a triangular distribution.
    function automatic logic [OW-1:0] hat(input logic [DW-1:0] x);
        return {1'b0, x[31:17]} + {1'b0, x[15:1]};
    endfunction

    // Stand-in datapath: result appears LAT cycles after its word.
    logic [DW-1:0] hist [LAT];
    always @(posedge clk) begin
        hist[0] <= dp_in;
        for (int s = 1; s < LAT; s++) hist[s] <= hist[s-1];
    end
    assign dp_out = hat(hist[LAT-1]);

    // Reference model state.
    typedef struct {
        int             due;
        int             idx;
        logic [OW-1:0]  val;
    } pend_t;

    pend_t              pend [$];
    logic [NREQ-1:0]    m_valid;
    logic [NREQ*OW-1:0] m_data;
    int                 m_ptr;
    int                 cyc;

    int total = 0;
    int bad   = 0;

    logic [NREQ-1:0]    cap_ready;
    logic [NREQ-1:0]    cap_rv;
    logic [NREQ*OW-1:0] cap_rd;
    logic [DW-1:0]      cap_dp;
    logic               cap_busy;

    logic [NREQ-1:0] seq_tbl [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_valid = '0;
        m_data  = '0;
        m_ptr   = 0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_dp_in"},     64'(dp_in),     64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_data"},  64'(rsp_data),  64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    task automatic rand_data();
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = $urandom;
    endtask

    // One clock cycle: compare at negedge against the model, then advance the model across the edge.
    task automatic step();
        int              g;
        int              j;
        bit              fl;
        bit              hit;
        logic [OW-1:0]   val;
        logic [NREQ-1:0] e_ready;
        logic [DW-1:0]   e_dp;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            j  = (m_ptr + k) % NREQ;
            fl = 1'b0;
            foreach (pend[p]) if (pend[p].idx == j) fl = 1'b1;
            if (g < 0 && req_valid[j] && en && !fl && (!m_valid[j] || rsp_ready[j])) g = j;
        end
        e_ready = '0;
        e_dp    = '0;
        if (g >= 0) begin
            e_ready[g] = 1'b1;
            e_dp       = req_data[g*DW +: DW];
        end
        cap_ready = req_ready;
        cap_rv    = rsp_valid;
        cap_rd    = rsp_data;
        cap_dp    = dp_in;
        cap_busy  = busy;
        check("req_ready", 64'(req_ready), 64'(e_ready));
        check("dp_in",     64'(dp_in),     64'(e_dp));
        check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        check("rsp_data",  64'(rsp_data),  64'(m_data));
        check("busy",      64'(busy),      64'((pend.size() != 0) || (|m_valid)));

        for (int i = 0; i < NREQ; i++) begin
            hit = 1'b0;
            val = '0;
            foreach (pend[p]) if (pend[p].due == cyc && pend[p].idx == i) begin
                hit = 1'b1;
                val = pend[p].val;
            end
            if (hit) begin
                m_valid[i]          = 1'b1;
                m_data[i*OW +: OW]  = val;
            end else if (rsp_ready[i]) begin
                m_valid[i] = 1'b0;
            end
        end
        for (int p = pend.size() - 1; p >= 0; p--) if (pend[p].due == cyc) pend.delete(p);
        if (g >= 0) begin
            pend.push_back('{due: cyc + LAT, idx: g, val: hat(req_data[g*DW +: DW])});
            m_ptr = (g + 1) % NREQ;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int arrivals;
        cyc = 0;
        model_reset();

        // Reset held with active inputs: everything stays quiet.
        reset     = 1'b0;
        en        = 1'b1;
        req_valid = '1;
        rsp_ready = '1;
        req_data  = '0;
        rand_data();
        repeat (2) @(posedge clk);
        #1;
        reset_checks("por");

        // Single requester, first grant right after release, result LAT+1 cycles later.
        req_valid          = 4'b0001;
        req_data[31:0]     = 32'hA468DAF5;
        rsp_ready          = 4'b1111;
        reset              = 1'b1;
        for (int c = 0; c < 7; c++) begin
            step();
            if (c == 0) check("single_grant", 64'(cap_ready), 64'(4'b0001));
            if (c == LAT + 1) begin
                check("single_rsp_valid", 64'(cap_rv[0]), 64'd1);
                check("single_rsp_data",  64'(cap_rd[OW-1:0]), 64'(hat(32'hA468DAF5)));
            end
        end

        // Pulse reset so the pointer restarts at 0, then run all four requesters.
        reset = 1'b0;
        #1;
        reset_checks("rst2");
        model_reset();
        @(posedge clk);
        #1;
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        reset     = 1'b1;
        for (int c = 0; c < 12; c++) begin
            rand_data();
            step();
            if (c < 5) check("rr_sequence", 64'(cap_ready), 64'(seq_tbl[c]));
            if (c >= 4) check("one_rsp_per_cycle", 64'($countones(cap_rv)), 64'd1);
        end

        // Backpressure on requester 2.
        rsp_ready = 4'b1011;
        for (int c = 0; c < 12; c++) begin
            rand_data();
            step();
            if (cap_rv[2]) check("bp_no_grant2", 64'(cap_ready[2]), 64'd0);
        end
        check("bp_buffer2_full", 64'(cap_rv[2]), 64'd1);
        req_valid = 4'b0100;
        rsp_ready = 4'b1111;
        step();
        check("bp_release_grant", 64'(cap_ready), 64'(4'b0100));
        for (int c = 0; c < 6; c++) step();

        // Drain and capture on the same edge for requester 1.
        req_valid = 4'b0010;
        for (int c = 0; c < 12; c++) begin
            rand_data();
            step();
        end

        // Issue enable dropped mid-stream.
        req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            rand_data();
            step();
        end
        en       = 1'b0;
        arrivals = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("en_off_ready", 64'(cap_ready), 64'd0);
            check("en_off_dp_in", 64'(cap_dp), 64'd0);
            if (c >= 1) arrivals += $countones(cap_rv);
            if (c == 4) check("en_off_busy_low", 64'(cap_busy), 64'd0);
        end
        check("en_off_arrivals", 64'(arrivals), 64'd3);

        // Reset pulsed with words in flight.
        en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            rand_data();
            step();
        end
        check("mid_busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        reset_checks("mid");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            rand_data();
            step();
            if (c == 0) check("post_rst_first_grant", 64'(cap_ready), 64'(4'b0001));
            if (c <= LAT) check("post_rst_no_stale", 64'(cap_rv), 64'd0);
        end

        // Random traffic.
        for (int c = 0; c < 500; c++) begin
            req_valid = 4'($urandom);
            for (int i = 0; i < NREQ; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 7) != 0);
            rand_data();
            step();
        end

        // Let everything drain.
        en        = 1'b0;
        rsp_ready = '1;
        for (int c = 0; c < LAT + 3; c++) step();
        check("final_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
